// File: rtl/hi_trace_trigger_pkg.sv
// Shared definitions for the HF trace trigger: FSM encoding, default sizing
// and small byte helpers used by the amplitude detector.
package hi_trace_trigger_pkg;

  localparam int DEF_WIN_LEN       = 16;
  localparam int DEF_QUIET_WINDOWS = 4;
  localparam int DEF_MAX_SAMPLES   = 3072;
  localparam int DIV_W             = 3;
  localparam int QUIET_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hi_trace_trigger_amp.sv
// Min/max peak-to-peak detector over WIN_LEN sample strobes; the last sample
// of a window seeds the next window's min/max.
module hi_trace_amp
  import hi_trace_trigger_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic       ck_1356megb,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       strobe,
  input  logic [7:0] adc_d,
  output logic [7:0] amp,
  output logic       win_valid
);

  localparam int CNT_W = $clog2(WIN_LEN);

  logic [CNT_W-1:0] win_cnt;
  logic [7:0]       min_q;
  logic [7:0]       max_q;
  logic [7:0]       lo;
  logic [7:0]       hi;

  assign lo = min8(min_q, adc_d);
  assign hi = max8(max_q, adc_d);

  always_ff @(negedge ck_1356megb or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      min_q     <= 8'hFF;
      max_q     <= 8'h00;
      amp       <= 8'h00;
      win_valid <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (clear) begin
        win_cnt <= '0;
        min_q   <= 8'hFF;
        max_q   <= 8'h00;
      end else if (strobe) begin
        if (win_cnt == CNT_W'(WIN_LEN - 1)) begin
          // hi >= lo always holds once a sample has been folded in
          amp       <= hi - lo;
          win_valid <= 1'b1;
          min_q     <= adc_d;
          max_q     <= adc_d;
          win_cnt   <= '0;
        end else begin
          min_q   <= lo;
          max_q   <= hi;
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hi_trace_trigger.sv
// Activity-triggered trace capture controller: arms on request, starts capture
// on the first active window, stops after a quiet run or the RAM length limit.
module hi_trace_trigger
  import hi_trace_trigger_pkg::*;
#(
  parameter int WIN_LEN       = DEF_WIN_LEN,
  parameter int QUIET_WINDOWS = DEF_QUIET_WINDOWS,
  parameter int MAX_SAMPLES   = DEF_MAX_SAMPLES
) (
  input  logic       ck_1356megb,
  input  logic       rst_n,
  input  logic [7:0] adc_d,
  input  logic       arm,
  input  logic [7:0] threshold,
  output logic       trace_enable,
  output logic       sample_strobe,
  output logic       triggered,
  output logic       done,
  output state_t     fsm_state
);

  localparam int SCNT_W = $clog2(MAX_SAMPLES + 1);

  logic [DIV_W-1:0]   div_q;
  state_t             state_q;
  state_t             state_d;
  logic [QUIET_W-1:0] quiet_q;
  logic [QUIET_W-1:0] quiet_d;
  logic [SCNT_W-1:0]  samp_q;
  logic [SCNT_W-1:0]  samp_d;
  logic               clear_win;
  logic               hit_limit;
  logic               hit_quiet;
  logic [7:0]         amp;
  logic               win_valid;
  logic               active;

  assign sample_strobe = (div_q == DIV_W'(7));
  assign active        = win_valid && (amp >= threshold);

  always_ff @(negedge ck_1356megb or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_q + 1'b1;
  end

  hi_trace_amp #(
    .WIN_LEN(WIN_LEN)
  ) u_amp (
    .ck_1356megb(ck_1356megb),
    .rst_n      (rst_n),
    .clear      (clear_win),
    .strobe     (sample_strobe),
    .adc_d      (adc_d),
    .amp        (amp),
    .win_valid  (win_valid)
  );

  always_ff @(negedge ck_1356megb or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      quiet_q <= '0;
      samp_q  <= '0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      samp_q  <= samp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    quiet_d   = quiet_q;
    samp_d    = samp_q;
    clear_win = 1'b0;
    hit_limit = 1'b0;
    hit_quiet = 1'b0;
    if (!arm) begin
      state_d = ST_IDLE;
      quiet_d = '0;
      samp_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ARMED;
          clear_win = 1'b1;
        end
        ST_ARMED: begin
          if (active) begin
            state_d = ST_CAPTURE;
            quiet_d = QUIET_W'(QUIET_WINDOWS);
            samp_d  = '0;
          end
        end
        ST_CAPTURE: begin
          if (sample_strobe) begin
            samp_d    = samp_q + 1'b1;
            hit_limit = (samp_d == SCNT_W'(MAX_SAMPLES));
          end
          // Decrementing out of 1 is the quiet end; DONE is taken, not a 0 count
          if (win_valid) begin
            if (active) begin
              quiet_d = QUIET_W'(QUIET_WINDOWS);
            end else if (quiet_q <= QUIET_W'(1)) begin
              quiet_d   = '0;
              hit_quiet = 1'b1;
            end else begin
              quiet_d = quiet_q - 1'b1;
            end
          end
          if (hit_limit || hit_quiet) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign trace_enable = (state_q == ST_CAPTURE);
  assign triggered    = (state_q == ST_CAPTURE) || (state_q == ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_hi_trace_trigger.sv
// Randomized bench for hi_trace_trigger against a window/queue based reference
// model; outputs sampled on posedge, away from the negedge the design uses.
module tb_hi_trace_trigger;
  import hi_trace_trigger_pkg::*;

  localparam int WIN   = DEF_WIN_LEN;
  localparam int QW    = DEF_QUIET_WINDOWS;
  localparam int MAXS  = DEF_MAX_SAMPLES;

  logic       ck_1356megb;
  logic       rst_n;
  logic [7:0] adc_d;
  logic       arm;
  logic [7:0] threshold;
  logic       trace_enable;
  logic       sample_strobe;
  logic       triggered;
  logic       done;
  state_t     fsm_state;

  hi_trace_trigger dut (
    .ck_1356megb  (ck_1356megb),
    .rst_n        (rst_n),
    .adc_d        (adc_d),
    .arm          (arm),
    .threshold    (threshold),
    .trace_enable (trace_enable),
    .sample_strobe(sample_strobe),
    .triggered    (triggered),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial ck_1356megb = 1'b0;
  always #37 ck_1356megb = ~ck_1356megb;

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 waiting for activity, 2 capturing, 3 finished
  int         m_edges   = 0;
  int         m_phase   = 0;
  int         m_strobes = 0;
  int         m_nsamp   = 0;
  int         m_quiet   = 0;
  int         m_captured = 0;
  logic [7:0] m_amp     = 8'h00;
  bit         m_wv      = 1'b0;
  logic [7:0] win_q[$];

  function automatic logic [7:0] span_of(input logic [7:0] q[$]);
    int lo, hi;
    lo = 255;
    hi = 0;
    foreach (q[i]) begin
      if (q[i] < lo) lo = q[i];
      if (q[i] > hi) hi = q[i];
    end
    return 8'(hi - lo);
  endfunction

  always @(negedge ck_1356megb or negedge rst_n) begin
    bit strobe_now, active_now, enter_arm, stop;
    int next_phase;
    if (!rst_n) begin
      m_edges = 0; m_phase = 0; m_nsamp = 0; m_quiet = 0; m_captured = 0;
      m_amp = 8'h00; m_wv = 1'b0;
      win_q.delete();
    end else begin
      strobe_now = ((m_edges % 8) == 7);
      active_now = m_wv && (m_amp >= threshold);
      enter_arm  = 1'b0;
      stop       = 1'b0;
      next_phase = m_phase;
      if (!arm) next_phase = 0;
      else if (m_phase == 0) begin
        next_phase = 1;
        enter_arm  = 1'b1;
      end else if (m_phase == 1) begin
        if (active_now) begin
          next_phase = 2;
          m_quiet    = QW;
          m_captured = 0;
        end
      end else if (m_phase == 2) begin
        if (strobe_now) begin
          m_captured++;
          if (m_captured == MAXS) stop = 1'b1;
        end
        if (m_wv) begin
          if (active_now) m_quiet = QW;
          else begin
            m_quiet--;
            if (m_quiet == 0) stop = 1'b1;
          end
        end
        if (stop) next_phase = 3;
      end
      m_wv = 1'b0;
      if (enter_arm) begin
        win_q.delete();
        m_nsamp = 0;
      end else if (strobe_now) begin
        win_q.push_back(adc_d);
        m_nsamp++;
        if (m_nsamp == WIN) begin
          m_amp = span_of(win_q);
          m_wv  = 1'b1;
          win_q.delete();
          win_q.push_back(adc_d);
          m_nsamp = 0;
        end
      end
      if (strobe_now) m_strobes++;
      m_phase = next_phase;
      m_edges++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int cap_strobes = 0;
  int adc_mode = 0;
  logic [7:0] adc_const = 8'd128;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("trace_enable", 32'(trace_enable), 32'(m_phase == 2));
    check("sample_strobe", 32'(sample_strobe), 32'((m_edges % 8) == 7));
    check("triggered", 32'(triggered), 32'(m_phase >= 2));
    check("done", 32'(done), 32'(m_phase == 3));
  endtask

  // ---------------- drivers ----------------
  task automatic drive_adc();
    case (adc_mode)
      0: adc_d = adc_const;
      1: adc_d = (m_strobes % 2) ? 8'd160 : 8'd100;
      2: adc_d = 8'($urandom_range(0, 255));
      default: adc_d = 8'(120 + $urandom_range(0, 15));
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ck_1356megb);
      check_outputs();
      if (trace_enable && sample_strobe) cap_strobes++;
      drive_adc();
    end
  endtask

  // which: 0 = trace_enable high, 1 = done high
  task automatic wait_for(input int which, input int budget, input string tag);
    int k;
    k = 0;
    while (((which == 0) ? trace_enable : done) !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) check(tag, 32'(0), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; adc_d = 8'd128; threshold = 8'd0;
    @(posedge ck_1356megb);
    check_outputs();
    @(posedge ck_1356megb);
    rst_n = 1'b1;

    // idle: strobe cadence, no capture
    adc_mode = 0;
    step(40);

    // alternating 100/160 with threshold 40 triggers on the first window
    threshold = 8'd40;
    adc_mode  = 1;
    arm       = 1'b1;
    wait_for(0, 400, "trigger_timeout");
    step(1);
    check("triggered_after_alt", 32'(triggered), 32'(1));

    // input goes quiet: done after the quiet windows
    adc_mode  = 0;
    adc_const = 8'd128;
    wait_for(1, 1200, "quiet_done_timeout");
    step(20);
    check("done_held", 32'(done), 32'(1));

    // continuous activity: length limit ends the capture
    arm = 1'b0;
    step(3);
    adc_mode = 2;
    arm = 1'b1;
    cap_strobes = 0;
    wait_for(0, 400, "limit_trigger_timeout");
    wait_for(1, 30000, "limit_done_timeout");
    check("limit_strobes", 32'(cap_strobes), 32'(MAXS));
    step(50);
    check("no_retrigger", 32'(trace_enable), 32'(0));

    // abort mid-capture, then re-arm
    arm = 1'b0;
    step(2);
    arm = 1'b1;
    wait_for(0, 400, "abort_trigger_timeout");
    step(100);
    arm = 1'b0;
    step(2);
    check("abort_idle", 32'(fsm_state), 32'(ST_IDLE));
    arm = 1'b1;
    wait_for(0, 400, "rearm_trigger_timeout");
    step(10);

    // random mix of thresholds, activity levels and arm toggles
    for (int i = 0; i < 30; i++) begin
      threshold = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(10, 80));
      adc_mode  = $urandom_range(0, 3);
      adc_const = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) arm = ~arm;
      step($urandom_range(50, 300));
    end

    // asynchronous reset during capture
    threshold = 8'd40;
    adc_mode  = 2;
    arm = 1'b0;
    step(2);
    arm = 1'b1;
    wait_for(0, 400, "rst_trigger_timeout");
    step(30);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_te", 32'(trace_enable), 32'(0));
    check("rst_async_trig", 32'(triggered), 32'(0));
    check("rst_async_done", 32'(done), 32'(0));
    arm = 1'b0;
    @(posedge ck_1356megb);
    #2 rst_n = 1'b1;
    #1;
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_min", 32'(dut.u_amp.min_q), 32'(8'hFF));
    check("rst_max", 32'(dut.u_amp.max_q), 32'(8'h00));
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
